// File: rtl/audio_pwm_capture_if.sv
// Sample stream handshake between audio_pwm_capture and its consumer.
// The master side is the capture block: it presents the FIFO head sample and
// its valid flag. The slave side (the consumer) returns sample_ready.
interface audio_pwm_capture_if;

  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/audio_pwm_capture.sv
// audio_pwm_capture: recovers 8-bit unsigned audio samples from a 1-bit PWM
// stream with a 256-clock frame. Each frame counts the clocks in which the
// conditioned input is high, saturates the count to 8 bits and queues the
// result in a small circular FIFO drained through a valid/ready handshake.
//
// Optional feature: define PWM_CAPTURE_GLITCH_FILTER_EN to insert a 3-tap
// majority filter after the input synchronizer. This rejects isolated
// single-clock pulses and raises the input latency from 2 to 4 clocks.
// The default build (macro undefined) feeds the synchronizer output straight
// into the high counter.
//
// FIFO_DEPTH must be a power of two in 2..16 so that the pointers wrap
// naturally on overflow of their binary width.
module audio_pwm_capture #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       pwm_in,
  input  logic                       clr_ovf,
  audio_pwm_capture_if.master        smp,
  output logic                       overflow,
  output logic                       frame_sync
);

  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       pwm_bit;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] tap_q;
  logic       flt_q;
  logic       maj;

  // Majority of the current synchronizer output and the two previous ones.
  assign maj = (sync_q[1] & tap_q[0]) | (sync_q[1] & tap_q[1]) | (tap_q[0] & tap_q[1]);

  // Filter delay line plus a registered majority output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
      flt_q <= 1'b0;
    end else begin
      tap_q <= {tap_q[0], sync_q[1]};
      flt_q <= maj;
    end
  end

  assign pwm_bit = flt_q;
`else
  assign pwm_bit = sync_q[1];
`endif

  // ---------------------------------------------------------------------------
  // Frame measurement
  // ---------------------------------------------------------------------------
  logic [7:0] frame_cnt_q;
  logic [8:0] high_cnt_q;
  logic [8:0] high_total;
  logic [7:0] sample_new;
  logic       frame_close;

  // The closing clock's own bit is part of the frame; 256 saturates to 8'hFF.
  assign frame_close = ena && (frame_cnt_q == 8'hFF);
  assign high_total  = high_cnt_q + {8'd0, pwm_bit};
  assign sample_new  = high_total[8] ? 8'hFF : high_total[7:0];
  assign frame_sync  = frame_close;

  // Frame and high counters; both parked at zero while disabled so that a
  // fresh enable always starts a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      high_cnt_q  <= '0;
    end else if (!ena) begin
      frame_cnt_q <= '0;
      high_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
      high_cnt_q  <= frame_close ? 9'd0 : high_total;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             push_ok;
  logic             ovf_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign push    = frame_close;
  assign pop     = !empty && smp.sample_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // Occupancy next state from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      count_q <= count_d;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= sample_new;
    end
  end

  // Head is masked while empty so the output reads zero during and after reset.
  assign smp.sample_valid = !empty;
  assign smp.sample_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------

  // Sticky drop indicator; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
